// File: rtl/demux3_buffer.sv
// demux3_buffer: routes a valid/ready input stream into three one-entry channel registers,
// discarding words whose destination code is invalid and counting them.
module demux3_buffer #(
   parameter int LARGURA      = 32,
   parameter int LARGURA_CONT = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    entrada_valida,
   output logic                    entrada_pronta,
   input  logic [1:0]              selecao,
   input  logic [LARGURA-1:0]      entrada,
   output logic [LARGURA-1:0]      saida1,
   output logic [LARGURA-1:0]      saida2,
   output logic [LARGURA-1:0]      saida3,
   output logic                    saida1_valida,
   output logic                    saida2_valida,
   output logic                    saida3_valida,
   input  logic                    saida1_pronta,
   input  logic                    saida2_pronta,
   input  logic                    saida3_pronta,
   output logic [LARGURA_CONT-1:0] descartes
);
   logic [LARGURA-1:0]      dado_q [3];
   logic [LARGURA-1:0]      dado_d [3];
   logic [2:0]              valida_q, valida_d, pronta, carga;
   logic [3:0]              alvo, livre;
   logic [LARGURA_CONT-1:0] cont_q, cont_d;
   logic                    xfer, descarte;
   assign pronta = {saida3_pronta, saida2_pronta, saida1_pronta};
   // index 3 (discard) is always free, so readiness only ever looks at the selected slot
   assign livre  = {1'b1, ~valida_q | pronta};
   assign alvo   = 4'b0001 << selecao;
   assign entrada_pronta = livre[selecao];
   assign xfer     = entrada_valida && entrada_pronta;
   assign carga    = alvo[2:0] & {3{xfer}};
   assign descarte = xfer && alvo[3];
   always_comb begin
      valida_d = carga | (valida_q & ~pronta);
      for (int k = 0; k < 3; k++) dado_d[k] = carga[k] ? entrada : dado_q[k];
      cont_d = cont_q + LARGURA_CONT'(descarte && !(&cont_q));
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 3; k++) dado_q[k] <= '0;
         valida_q <= '0;
         cont_q   <= '0;
      end else begin
         for (int k = 0; k < 3; k++) dado_q[k] <= dado_d[k];
         valida_q <= valida_d;
         cont_q   <= cont_d;
      end
   end
   assign saida1        = dado_q[0];
   assign saida2        = dado_q[1];
   assign saida3        = dado_q[2];
   assign saida1_valida = valida_q[0];
   assign saida2_valida = valida_q[1];
   assign saida3_valida = valida_q[2];
   assign descartes     = cont_q;
endmodule
